// File: rtl/game_flow_ctrl.sv
// Game-flow FSM for the FireBoy/IceGirl top level: level progression, shared lives,
// timed revive and loader handshake. Define GAME_FLOW_PAUSE_EN to enable the PAUSED state.
module game_flow_ctrl #(
  parameter int NUM_PLAYERS   = 2,
  parameter int NUM_LEVELS    = 4,
  parameter int LIVES         = 3,
  parameter int REVIVE_FRAMES = 60,
  localparam int LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int VW = (LIVES > 0) ? $clog2(LIVES + 1) : 1,
  localparam int CW = (REVIVE_FRAMES > 0) ? $clog2(REVIVE_FRAMES + 1) : 1
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_tick,
  input  logic                   start,
  input  logic [NUM_PLAYERS-1:0] player_dead,
  input  logic [NUM_PLAYERS-1:0] player_at_door,
  input  logic                   level_ready,
  output logic [2:0]             state,
  output logic [LW-1:0]          level,
  output logic [VW-1:0]          lives,
  output logic [NUM_PLAYERS-1:0] player_en,
  output logic [NUM_PLAYERS-1:0] revive,
  output logic                   level_load,
  output logic                   gameover,
  output logic                   gamewin
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_PLAY    = 3'd2,
    S_DYING   = 3'd3,
    S_LVLDONE = 3'd4,
    S_OVER    = 3'd5,
    S_WIN     = 3'd6,
    S_PAUSED  = 3'd7
  } state_t;

  state_t        cur;
  logic          start_q;
  logic          start_edge;
  logic [LW-1:0] lvl_r;
  logic [VW-1:0] lives_r;
  logic [CW-1:0] cnt;
  logic          rev_pend;

  assign start_edge = start & ~start_q;

  // Outputs decode the pre-edge state, so every output trails its transition by one cycle;
  // rev_pend marks entries into PLAY that must emit a revive pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cur        <= S_IDLE;
      start_q    <= 1'b0;
      lvl_r      <= '0;
      lives_r    <= '0;
      cnt        <= '0;
      rev_pend   <= 1'b0;
      state      <= '0;
      level      <= '0;
      lives      <= '0;
      player_en  <= '0;
      revive     <= '0;
      level_load <= 1'b0;
      gameover   <= 1'b0;
      gamewin    <= 1'b0;
    end else begin
      start_q    <= start;
      rev_pend   <= 1'b0;
      state      <= cur;
      level      <= lvl_r;
      lives      <= lives_r;
      player_en  <= {NUM_PLAYERS{cur == S_PLAY}};
      revive     <= {NUM_PLAYERS{rev_pend}};
      level_load <= (cur == S_LOAD);
      gameover   <= (cur == S_OVER);
      gamewin    <= (cur == S_WIN);

      case (cur)
        S_IDLE: begin
          if (start_edge) begin
            lvl_r   <= '0;
            lives_r <= VW'(LIVES);
            cur     <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (level_ready) begin
            rev_pend <= 1'b1;
            cur      <= S_PLAY;
          end
        end

        S_PLAY: begin
          if (|player_dead) begin
            if (lives_r == '0) begin
              cur <= S_OVER;
            end else begin
              lives_r <= lives_r - VW'(1);
              cnt     <= CW'(REVIVE_FRAMES);
              cur     <= S_DYING;
            end
          end else if (&player_at_door) begin
            cur <= S_LVLDONE;
          end
`ifdef GAME_FLOW_PAUSE_EN
          else if (start_edge) begin
            cur <= S_PAUSED;
          end
`endif
        end

        S_DYING: begin
          if (REVIVE_FRAMES == 0) begin
            rev_pend <= 1'b1;
            cur      <= S_PLAY;
          end else if (frame_tick) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              rev_pend <= 1'b1;
              cur      <= S_PLAY;
            end
          end
        end

        S_LVLDONE: begin
          if (lvl_r == LW'(NUM_LEVELS - 1)) begin
            cur <= S_WIN;
          end else begin
            lvl_r <= lvl_r + LW'(1);
            cur   <= S_LOAD;
          end
        end

        S_OVER, S_WIN: begin
          if (start_edge) begin
            lvl_r   <= '0;
            lives_r <= VW'(LIVES);
            cur     <= S_LOAD;
          end
        end

        S_PAUSED: begin
`ifdef GAME_FLOW_PAUSE_EN
          if (start_edge) begin
            cur <= S_PLAY;
          end
`else
          cur <= S_IDLE;
`endif
        end

        default: cur <= S_IDLE;
      endcase
    end
  end

endmodule
